// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: datapath width, M-extension funct3 encodings and
// the multiply/divide sequencer state type.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = XLEN;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } m_funct3_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX,
    MD_DONE
  } muldiv_state_e;

  function automatic logic f3_is_div(input m_funct3_e f);
    return f[2];
  endfunction

  function automatic logic f3_is_rem(input m_funct3_e f);
    return f inside {F3_REM, F3_REMU};
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide on operand magnitudes, sign fix-up at the end, stall while busy.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  import riscv_pkg::*;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     r_state, w_next_state;
  logic [5:0]        r_cnt;
  m_funct3_e         r_op;
  logic [XLEN-1:0]   r_mag_a, r_mag_b;
  logic              r_sa, r_sb;
  logic [4:0]        r_rd;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  m_funct3_e         w_op;
  logic              w_sa, w_sb, w_accept, w_special, w_div_zero, w_overflow;
  logic [XLEN:0]     w_ext_a, w_ext_b;
  logic [XLEN-1:0]   w_abs_a, w_abs_b, w_special_result;
  logic [XLEN:0]     w_mul_sum, w_div_shift, w_div_diff;
  logic              w_qbit;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_prod;
  logic [XLEN-1:0]   w_quot, w_rem, w_fix_result;

  // Operand decode: which operands are signed, and their 33-bit magnitudes so
  // that |INT_MIN| is representable.
  assign w_op     = m_funct3_e'(op);
  assign w_sa     = !(w_op inside {F3_MULHU, F3_DIVU, F3_REMU}) & rs1_val[XLEN-1];
  assign w_sb     = (w_op inside {F3_MUL, F3_MULH, F3_DIV, F3_REM}) & rs2_val[XLEN-1];
  assign w_ext_a  = {w_sa, rs1_val};
  assign w_ext_b  = {w_sb, rs2_val};
  assign w_abs_a  = XLEN'(w_sa ? -w_ext_a : w_ext_a);
  assign w_abs_b  = XLEN'(w_sb ? -w_ext_b : w_ext_b);

  assign w_accept   = (r_state == MD_IDLE) & start & ~flush;
  assign w_div_zero = (rs2_val == '0);
  assign w_overflow = (w_op inside {F3_DIV, F3_REM}) & (rs1_val == INT_MIN) & (rs2_val == '1);
  assign w_special  = f3_is_div(w_op) & (w_div_zero | w_overflow);

  always_comb begin
    w_special_result = '0;
    if (w_div_zero)
      w_special_result = f3_is_rem(w_op) ? rs1_val : '1;
    else if (!f3_is_rem(w_op))
      w_special_result = INT_MIN;
  end

  // One multiply step: add multiplicand if multiplier LSB set, shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // One restoring-divide step on {remainder, quotient}.
  assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_mag_b};
  assign w_qbit      = ~w_div_diff[XLEN];
  assign w_div_next  = {w_qbit ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0],
                        r_acc[XLEN-2:0], w_qbit};

  assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quot = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    unique case (r_op)
      F3_MUL:                       w_fix_result = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fix_result = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_fix_result = w_quot;
      default:                      w_fix_result = w_rem;
    endcase
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      MD_IDLE: if (w_accept) w_next_state = w_special ? MD_DONE : MD_CALC;
      MD_CALC: if (flush) w_next_state = MD_IDLE;
               else if (r_cnt == 6'(ITERS-1)) w_next_state = MD_FIX;
      MD_FIX:  w_next_state = flush ? MD_IDLE : MD_DONE;
      MD_DONE: w_next_state = MD_IDLE;
      default: w_next_state = MD_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples values from before the edge, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= MD_IDLE;
      r_cnt    <= '0;
      r_op     <= F3_MUL;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_rd     <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      r_state <= w_next_state;
      unique case (r_state)
        MD_IDLE: if (w_accept) begin
          r_op    <= w_op;
          r_mag_a <= w_abs_a;
          r_mag_b <= w_abs_b;
          r_sa    <= w_sa;
          r_sb    <= w_sb;
          r_rd    <= rd_in;
          r_cnt   <= '0;
          r_acc   <= {{XLEN{1'b0}}, f3_is_div(w_op) ? w_abs_a : w_abs_b};
          if (w_special) begin
            r_result <= w_special_result;
            r_rd_out <= rd_in;
          end
        end
        MD_CALC: if (!flush) begin
          r_acc <= f3_is_div(r_op) ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 6'd1;
        end
        MD_FIX: if (!flush) begin
          r_result <= w_fix_result;
          r_rd_out <= r_rd;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != MD_IDLE);
  assign stall_req = w_accept | (r_state == MD_CALC) | (r_state == MD_FIX);
  assign done      = (r_state == MD_DONE);
  assign result    = r_result;
  assign rd_out    = r_rd_out;

endmodule
